// File: rtl/arith_pkg.sv
// Shared types and constants for the arithmetic datapath blocks
// (multiplier, sequential divider).
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ARITH_W = 4;

  // Step counter width; a 1-bit counter is kept even for degenerate widths
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module div_step
  import arith_pkg::*;
#(
  parameter int W = ARITH_W
) (
  input  logic [W:0]   rem,
  input  logic [W-1:0] dvs,
  input  logic         dvd_bit,
  output logic [W:0]   rem_next,
  output logic         qbit
);

  logic [W+1:0] shifted;

  // One spare bit above the W+1 remainder keeps the compare exact
  always_comb begin
    shifted  = {rem, dvd_bit};
    qbit     = (shifted >= {2'b00, dvs});
    rem_next = qbit ? (W+1)'(shifted - {2'b00, dvs}) : shifted[W:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done
// handshake, registered quotient/remainder/divide-by-zero results.
module seq_divider
  import arith_pkg::*;
#(
  parameter int W = ARITH_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dvd,
  input  logic [W-1:0] dvs,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] q,
  output logic [W-1:0] r,
  output logic         dbz
);

  localparam int CW = cnt_width(W);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  dvs_r;
  logic [W:0]    rem;
  logic [W-1:0]  quo;

  logic [W:0]    rem_next;
  logic          qbit;
  logic [W-1:0]  quo_next;

  // quo starts out holding the dividend; its MSB is the next bit to bring down
  div_step #(.W(W)) u_step (
    .rem      (rem),
    .dvs      (dvs_r),
    .dvd_bit  (quo[W-1]),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  assign quo_next = {quo[W-2:0], qbit};

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      dvs_r <= '0;
      rem   <= '0;
      quo   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      q     <= '0;
      r     <= '0;
      dbz   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            dvs_r <= dvs;
            quo   <= dvd;
            rem   <= '0;
            cnt   <= CW'(W - 1);
            if (dvs != '0) begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end else begin
              // Divide-by-zero finishes at once with the all-ones convention
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              q     <= '1;
              r     <= dvd;
              dbz   <= 1'b1;
            end
          end else begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end

        RUN: begin
          rem <= rem_next;
          quo <= quo_next;
          if (cnt == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            q     <= quo_next;
            r     <= rem_next[W-1:0];
            dbz   <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed handshake/boundary cases,
// an exhaustive operand sweep and randomized start noise during RUN.
module tb_seq_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dvd;
  logic [W-1:0] dvs;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         dbz;

  int n_cmp = 0;
  int n_bad = 0;
  int prev_q = 0;
  int prev_r = 0;

  always #5 clk = ~clk;

  seq_divider #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .dvd   (dvd),
    .dvs   (dvs),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r),
    .dbz   (dbz)
  );

  // Reference: plain integer division with the all-ones / dividend
  // convention for a zero divisor
  function automatic int ref_q(input int a, input int b);
    return (b == 0) ? (1 << W) - 1 : a / b;
  endfunction

  function automatic int ref_r(input int a, input int b);
    return (b == 0) ? a : a % b;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int a, input int b);
    dvd   = W'(a);
    dvs   = W'(b);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
    if (!done) check_output("done_timeout", 0, 1);
  endtask

  task automatic check_result(input string tag, input int a, input int b);
    check_output($sformatf("%s_q %0d/%0d", tag, a, b), 32'(q), 32'(ref_q(a, b)));
    check_output($sformatf("%s_r %0d/%0d", tag, a, b), 32'(r), 32'(ref_r(a, b)));
    check_output($sformatf("%s_dbz %0d/%0d", tag, a, b), 32'(dbz), 32'(b == 0));
    prev_q = ref_q(a, b);
    prev_r = ref_r(a, b);
  endtask

  // Full operation with handshake, latency and hold checks
  task automatic run_op(input string tag, input int a, input int b);
    int lat, bcnt;
    apply_stimulus(a, b);
    check_output({tag, "_busy_acc"}, 32'(busy), 32'(b != 0));
    check_output({tag, "_done_acc"}, 32'(done), 32'(b == 0));
    if (b != 0) begin
      check_output({tag, "_hold_q"}, 32'(q), 32'(prev_q));
      check_output({tag, "_hold_r"}, 32'(r), 32'(prev_r));
    end
    wait_done(lat, bcnt);
    check_output({tag, "_latency"}, 32'(lat), (b == 0) ? 32'd0 : 32'(W));
    check_output({tag, "_busy_cycles"}, 32'(bcnt), (b == 0) ? 32'd0 : 32'(W));
    check_result(tag, a, b);
  endtask

  // Operation with random start/operand noise on every RUN cycle
  task automatic run_noisy(input string tag, input int a, input int b);
    int lat;
    apply_stimulus(a, b);
    lat = 0;
    while (!done && lat < 40) begin
      start = 1'($urandom_range(0, 1));
      dvd   = W'($urandom);
      dvs   = W'($urandom);
      tick();
      lat++;
    end
    start = 1'b0;
    if (!done) check_output({tag, "_timeout"}, 0, 1);
    check_output({tag, "_latency"}, 32'(lat), 32'(W));
    check_result(tag, a, b);
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (done) pulses++;
    end
  endtask

  initial begin
    int pulses, a, b;
    rst   = 1'b1;
    start = 1'b0;
    dvd   = '0;
    dvs   = '0;
    #12;
    check_output("reset_busy", 32'(busy), 0);
    check_output("reset_done", 32'(done), 0);
    check_output("reset_q", 32'(q), 0);
    check_output("reset_r", 32'(r), 0);
    check_output("reset_dbz", 32'(dbz), 0);
    rst = 1'b0;
    tick();

    $display("[TB] basic 13/3");
    run_op("t1", 13, 3);
    tick();
    check_output("t1_idle_done", 32'(done), 0);

    $display("[TB] back-to-back 5/7 then 15/1");
    run_op("t2a", 5, 7);
    run_op("t2b", 15, 1);

    $display("[TB] divide by zero then 6/2");
    tick();
    run_op("t3a", 9, 0);
    run_op("t3b", 6, 2);
    tick();

    $display("[TB] start ignored while running");
    apply_stimulus(12, 4);
    dvd   = 4'd1;
    dvs   = 4'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    dvd   = 4'd9;
    dvs   = 4'd0;
    begin
      int lat, bcnt;
      wait_done(lat, bcnt);
      check_output("t4_latency", 32'(lat), 32'(W - 1));
    end
    check_result("t4", 12, 4);
    count_done(6, pulses);
    check_output("t4_extra_done", 32'(pulses), 0);

    $display("[TB] reset mid-run");
    apply_stimulus(14, 3);
    tick();
    rst = 1'b1;
    #1;
    check_output("t5_busy", 32'(busy), 0);
    check_output("t5_done", 32'(done), 0);
    check_output("t5_q", 32'(q), 0);
    check_output("t5_r", 32'(r), 0);
    check_output("t5_dbz", 32'(dbz), 0);
    #3;
    rst = 1'b0;
    prev_q = 0;
    prev_r = 0;
    count_done(8, pulses);
    check_output("t5_no_done", 32'(pulses), 0);
    check_output("t5_idle_busy", 32'(busy), 0);

    $display("[TB] exhaustive sweep");
    for (int i = 0; i < 256; i++) begin
      run_op("sweep", i >> 4, i & 15);
      if ($urandom_range(0, 2) == 0) tick();
    end

    $display("[TB] random operands with start noise");
    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, 15);
      b = $urandom_range(1, 15);
      run_noisy("noisy", a, b);
      tick();
      check_output("noisy_single_done", 32'(done), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
